// File: rtl/srt_pkg.sv
// Shared types and constants for the parametrised radix-2 SRT divider.
package srt_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  // Quotient digit encoding: two's complement of {-1, 0, +1}.
  localparam logic [1:0] QPOS  = 2'b01;
  localparam logic [1:0] QZERO = 2'b00;
  localparam logic [1:0] QNEG  = 2'b11;

  // Thresholds on the top 3 bits of the shifted partial remainder.
  // Those bits weigh -2, +1, +1/2 relative to the normalised divisor scale,
  // so one LSB is 1/2 and the truncated estimate is exact at +-1/2.
  localparam logic signed [2:0] SEL_POS = 3'sd1;   // >= +1/2
  localparam logic signed [2:0] SEL_NEG = -3'sd1;  // <  -1/2

  function automatic logic [1:0] sel_digit(input logic signed [2:0] top);
    if (top >= SEL_POS)     return QPOS;
    else if (top < SEL_NEG) return QNEG;
    else                    return QZERO;
  endfunction

endpackage

// File: rtl/srt_otf_conv.sv
// On-the-fly converter: builds Q and QM = Q - 1 from signed-digit quotient
// digits, one digit per load, so no carry-propagate step is needed at the end.
module srt_otf_conv #(
  parameter int N_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           load,
  input  logic [1:0]     digit,
  output logic [N_W-1:0] q,
  output logic [N_W-1:0] qm
);
  import srt_pkg::*;

  logic [N_W-1:0] q_q, q_d;
  logic [N_W-1:0] qm_q, qm_d;

  // Next Q/QM: append the digit to whichever of Q or QM keeps both exact.
  always_comb begin
    q_d  = q_q;
    qm_d = qm_q;
    if (clear) begin
      q_d  = '0;
      qm_d = '1;
    end else if (load) begin
      case (digit)
        QPOS: begin
          q_d  = {q_q[N_W-2:0], 1'b1};
          qm_d = {q_q[N_W-2:0], 1'b0};
        end
        QNEG: begin
          q_d  = {qm_q[N_W-2:0], 1'b1};
          qm_d = {qm_q[N_W-2:0], 1'b0};
        end
        default: begin
          q_d  = {q_q[N_W-2:0], 1'b0};
          qm_d = {qm_q[N_W-2:0], 1'b1};
        end
      endcase
    end
  end

  // Q/QM registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q  <= '0;
      qm_q <= '1;
    end else begin
      q_q  <= q_d;
      qm_q <= qm_d;
    end
  end

  assign q  = q_q;
  assign qm = qm_q;

endmodule

// File: rtl/srt_div_p.sv
// Parametrised radix-2 SRT integer divider with valid/ready on both sides,
// signed/unsigned mode, fixed latency and divide-by-zero / overflow flags.
module srt_div_p #(
  parameter int N_W = 8,
  parameter int D_W = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           op_signed,
  input  logic [N_W-1:0] N,
  input  logic [D_W-1:0] D,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_W-1:0] Q,
  output logic [D_W-1:0] R,
  output logic           dz,
  output logic           ovf
);
  import srt_pkg::*;

  // Partial remainder holds 2P for P in [-Y, Y), Y = Dnorm << N_W.
  localparam int PW = N_W + D_W + 2;
  localparam int CW = $clog2(N_W);
  localparam int KW = $clog2(D_W);
  localparam logic [N_W-1:0] QMIN = {1'b1, {(N_W-1){1'b0}}};

  state_e         state_q, state_d;
  logic [N_W-1:0] n_q, n_d;
  logic [D_W-1:0] d_q, d_d;
  logic           sgn_q, sgn_d;
  logic [PW-1:0]  p_q, p_d;
  logic [D_W-1:0] dn_q, dn_d;
  logic [KW-1:0]  k_q, k_d;
  logic           sq_q, sq_d;
  logic           sr_q, sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N_W-1:0] q_q, q_d;
  logic [D_W-1:0] r_q, r_d;
  logic           dz_q, dz_d;
  logic           ovf_q, ovf_d;
  logic           out_valid_q, out_valid_d;

  logic [N_W-1:0] amag;
  logic [D_W-1:0] bmag;
  logic [KW-1:0]  lz;
  logic [PW-1:0]  p2, y;
  logic signed [2:0] sel_top;
  logic [1:0]     digit;
  logic           otf_clear, otf_load;
  logic [N_W-1:0] otf_q, otf_qm;
  logic           p_neg;
  logic [N_W-1:0] qmag;
  logic [D_W-1:0] rnorm, rmag;

  srt_otf_conv #(.N_W(N_W)) u_otf (
    .clk   (clk),
    .reset (reset),
    .clear (otf_clear),
    .load  (otf_load),
    .digit (digit),
    .q     (otf_q),
    .qm    (otf_qm)
  );

  // Operand magnitudes and the left shift that puts |D|'s MSB at the top.
  always_comb begin
    amag = (sgn_q && n_q[N_W-1]) ? -n_q : n_q;
    bmag = (sgn_q && d_q[D_W-1]) ? -d_q : d_q;
    lz   = '0;
    for (int i = 0; i < D_W; i++)
      if (bmag[i]) lz = KW'(D_W - 1 - i);
  end

  // Digit selection, iteration operands and final correction terms.
  always_comb begin
    p2      = p_q << 1;
    y       = {{(PW-D_W){1'b0}}, dn_q} << N_W;
    sel_top = p2[PW-1 -: 3];
    digit   = sel_digit(sel_top);
    p_neg   = p_q[PW-1];
    qmag    = p_neg ? otf_qm : otf_q;
    // Final P is a multiple of 2^N_W and lands in [0, Dnorm) after correction,
    // so the D_W-bit slice above N_W is the whole normalised remainder.
    rnorm   = p_neg ? p_q[N_W +: D_W] + dn_q : p_q[N_W +: D_W];
    rmag    = rnorm >> k_q;
  end

  // FSM next state, datapath updates and result loading.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    d_d         = d_q;
    sgn_d       = sgn_q;
    p_d         = p_q;
    dn_d        = dn_q;
    k_d         = k_q;
    sq_d        = sq_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    r_d         = r_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    otf_clear   = 1'b0;
    otf_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          n_d     = N;
          d_d     = D;
          sgn_d   = op_signed;
          state_d = PREP;
        end
      end
      PREP: begin
        p_d       = {{(PW-N_W){1'b0}}, amag} << lz;
        dn_d      = bmag << lz;
        k_d       = lz;
        sq_d      = sgn_q && (n_q[N_W-1] ^ d_q[D_W-1]);
        sr_d      = sgn_q && n_q[N_W-1];
        cnt_d     = '0;
        otf_clear = 1'b1;
        state_d   = ITER;
      end
      ITER: begin
        otf_load = 1'b1;
        case (digit)
          QPOS:    p_d = p2 - y;
          QNEG:    p_d = p2 + y;
          default: p_d = p2;
        endcase
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N_W - 1)) state_d = FIX;
      end
      FIX: begin
        if (d_q == '0) begin
          q_d   = '1;
          r_d   = n_q[D_W-1:0];
          dz_d  = 1'b1;
          ovf_d = 1'b0;
        end else begin
          q_d   = sq_q ? -qmag : qmag;
          r_d   = sr_q ? -rmag : rmag;
          dz_d  = 1'b0;
          // Magnitude too large for a signed result, except -2^(N_W-1) itself.
          ovf_d = sgn_q && qmag[N_W-1] && !(sq_q && qmag == QMIN);
        end
        state_d = DONE;
      end
      DONE: begin
        // out_valid is a flop that follows DONE by one cycle; the result
        // registers are already stable from FIX onwards.
        if (out_valid_q && out_ready) state_d = IDLE;
        else                          out_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand, datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      d_q         <= '0;
      sgn_q       <= 1'b0;
      p_q         <= '0;
      dn_q        <= '0;
      k_q         <= '0;
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      cnt_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      d_q         <= d_d;
      sgn_q       <= sgn_d;
      p_q         <= p_d;
      dn_q        <= dn_d;
      k_q         <= k_d;
      sq_q        <= sq_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      r_q         <= r_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign Q         = q_q;
  assign R         = r_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_srt_div_p.sv
// Bench for srt_div_p: directed table, reset-abort sequence, random ops
// checked against an integer-arithmetic reference.
module tb_srt_div_p;
  localparam int NW = 8;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          op_signed = 1'b0;
  logic [NW-1:0] N = '0;
  logic [DW-1:0] D = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NW-1:0] Q;
  logic [DW-1:0] R;
  logic          dz;
  logic          ovf;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic          sg;
    logic [NW-1:0] n;
    logic [DW-1:0] d;
    logic [NW-1:0] eq;
    logic [DW-1:0] er;
    logic          edz;
    logic          eov;
    int            hold;
  } vec_t;

  srt_div_p #(.N_W(NW), .D_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_signed (op_signed),
    .N         (N),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .dz        (dz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division, C-style truncation toward zero.
  task automatic ref_div(input logic sg, input logic [NW-1:0] n, input logic [DW-1:0] d,
                         output logic [NW-1:0] q, output logic [DW-1:0] r,
                         output logic edz, output logic eov);
    int ni, di, qi, ri;
    if (d == '0) begin
      q = '1; r = n[DW-1:0]; edz = 1'b1; eov = 1'b0;
    end else begin
      ni  = sg ? int'($signed(n)) : int'(n);
      di  = sg ? int'($signed(d)) : int'(d);
      qi  = ni / di;
      ri  = ni % di;
      q   = qi[NW-1:0];
      r   = ri[DW-1:0];
      edz = 1'b0;
      eov = sg && (qi > (2**(NW-1)) - 1 || qi < -(2**(NW-1)));
    end
  endtask

  // One full transaction: offer, busy period with junk on the bus, result
  // check, optional back-pressure hold, then release.
  task automatic run_op(input string nm, input logic sg, input logic [NW-1:0] n,
                        input logic [DW-1:0] d, input logic [NW-1:0] eq,
                        input logic [DW-1:0] er, input logic edz, input logic eov,
                        input int hold);
    int   lat;
    logic busy_rdy;
    op_signed = sg; N = n; D = d; in_valid = 1'b1;
    lat = 0;
    while (!in_ready && lat < 40) begin @(posedge clk); #1; lat++; end
    chk({nm, " offer in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    N = NW'($urandom); D = DW'($urandom); op_signed = ~sg;
    lat = 0; busy_rdy = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (in_ready) busy_rdy = 1'b1;
    end
    in_valid = 1'b0;
    chk({nm, " latency"}, 32'(lat), 32'(NW + 3));
    chk({nm, " busy in_ready"}, 32'(busy_rdy), 32'd0);
    chk({nm, " Q"}, 32'(Q), 32'(eq));
    chk({nm, " R"}, 32'(R), 32'(er));
    chk({nm, " flags"}, 32'({dz, ovf}), 32'({edz, eov}));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({nm, " hold"}, {10'd0, out_valid, in_ready, ovf, dz, R, Q},
          {10'd0, 1'b1, 1'b0, eov, edz, er, eq});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " release"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t          tbl[13];
    logic          rsg, edz, eov, seen;
    logic [NW-1:0] rn, eq;
    logic [DW-1:0] rd, er;

    tbl[0]  = '{1'b0, 8'h40, 6'h10, 8'h04, 6'h00, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 8'hFF, 6'h07, 8'h24, 6'h03, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 8'h9C, 6'h07, 8'hF2, 6'h3E, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b0, 8'h5A, 6'h00, 8'hFF, 6'h1A, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b1, 8'h80, 6'h3F, 8'h80, 6'h00, 1'b0, 1'b1, 5};
    tbl[5]  = '{1'b0, 8'h64, 6'h0A, 8'h0A, 6'h00, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b1, 8'h80, 6'h01, 8'h80, 6'h00, 1'b0, 1'b0, 0};
    tbl[7]  = '{1'b1, 8'h7F, 6'h20, 8'hFD, 6'h1F, 1'b0, 1'b0, 0};
    tbl[8]  = '{1'b0, 8'h05, 6'h3F, 8'h00, 6'h05, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b1, 8'h05, 6'h00, 8'hFF, 6'h05, 1'b1, 1'b0, 0};
    tbl[10] = '{1'b1, 8'hF9, 6'h02, 8'hFD, 6'h3F, 1'b0, 1'b0, 0};
    tbl[11] = '{1'b0, 8'hFF, 6'h01, 8'hFF, 6'h00, 1'b0, 1'b0, 2};
    tbl[12] = '{1'b1, 8'h64, 6'h3D, 8'hDF, 6'h01, 1'b0, 1'b0, 0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset QR", 32'({Q, R}), 32'd0);
    chk("reset flags", 32'({dz, ovf}), 32'd0);

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].sg, tbl[i].n, tbl[i].d,
             tbl[i].eq, tbl[i].er, tbl[i].edz, tbl[i].eov, tbl[i].hold);

    // Reset during the third iteration cycle aborts the division.
    op_signed = 1'b0; N = 8'h37; D = 6'h05; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort Q", 32'(Q), 32'd0);
    seen = 1'b0;
    repeat (NW + 6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort no result", 32'(seen), 32'd0);
    run_op("post abort", 1'b0, 8'h64, 6'h0A, 8'h0A, 6'h00, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      rsg = 1'($urandom_range(0, 1));
      rn  = NW'($urandom);
      rd  = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
      if (i % 10 == 5) begin rsg = 1'b1; rn = 8'h80; rd = '1; end
      ref_div(rsg, rn, rd, eq, er, edz, eov);
      run_op($sformatf("rnd%0d s%0d %0h/%0h", i, rsg, rn, rd), rsg, rn, rd,
             eq, er, edz, eov, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
